alu_mdu_unit: RTL and testbench

ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mdu_unit_if.sv | 28 ++
 rtl/alu_op_decode.sv | 51 +++++
 rtl/alu_mdu_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_mdu_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU/MDU unit: operation codes, FSM states and ALUOp classes.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

    localparam logic [6:0] FUNCT7_MEXT   = 7'b0000001;

    function automatic logic is_m_op(input alu_op_e o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                         OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_mul_op(input alu_op_e o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/alu_mdu_unit_if.sv
// Request/response bundle between an issuing stage and the ALU/MDU unit.
interface alu_mdu_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [6:0]      op;
    logic [2:0]      Funct3;
    logic [6:0]      Funct7;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;
    logic            Zero;
    logic            busy;

    modport master (
        output in_valid, ALUOp, op, Funct3, Funct7, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result, Zero, busy
    );

    modport slave (
        input  in_valid, ALUOp, op, Funct3, Funct7, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result, Zero, busy
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/opcode/funct decode into a single operation code.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op_c
);
    logic is_rtype;
    logic unused_op;

    // Only bit 5 of the opcode matters (R-type versus I-type).
    assign is_rtype  = op[5];
    assign unused_op = ^{op[6], op[4:0]};

    always_comb begin
        alu_op_c = OP_ADD;
        case (alu_class)
            ALUOP_ADD, ALUOP_ADD_ALT: alu_op_c = OP_ADD;
            ALUOP_SUB:                alu_op_c = OP_SUB;
            ALUOP_FUNCT: begin
                if (is_rtype && funct7 == FUNCT7_MEXT) begin
                    case (funct3)
                        3'b000: alu_op_c = OP_MUL;
                        3'b001: alu_op_c = OP_MULH;
                        3'b010: alu_op_c = OP_MULHSU;
                        3'b011: alu_op_c = OP_MULHU;
                        3'b100: alu_op_c = OP_DIV;
                        3'b101: alu_op_c = OP_DIVU;
                        3'b110: alu_op_c = OP_REM;
                        3'b111: alu_op_c = OP_REMU;
                    endcase
                end else begin
                    case (funct3)
                        3'b000: alu_op_c = (is_rtype && funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001: alu_op_c = OP_SLL;
                        3'b010: alu_op_c = OP_SLT;
                        3'b011: alu_op_c = OP_SLTU;
                        3'b100: alu_op_c = OP_XOR;
                        3'b101: alu_op_c = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110: alu_op_c = OP_OR;
                        3'b111: alu_op_c = OP_AND;
                    endcase
                end
            end
            default: alu_op_c = OP_ADD;
        endcase
    end
endmodule

// File: rtl/alu_mdu_unit.sv
// Single-issue ALU with an iterative radix-2 multiply/divide unit behind a
// valid/ready handshake; basic ops answer in one cycle, M ops after XLEN iterations.
module alu_mdu_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ZERO_FLAG_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    alu_mdu_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic ZERO_RST  = (ZERO_FLAG_EN != 0);

    state_e          state_q, state_d;
    alu_op_e         op_q, op_d, dec_op_c;
    logic [XLEN-1:0] a_q, a_d, d_q, d_d, hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d, negr_q, negr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic            busy_q, busy_d, zero_q, zero_d;

    logic [CW-1:0]   shamt_c;
    logic [XLEN-1:0] basic_res_c, mag_a_c, mag_b_c;
    logic            sign_a_c, sign_b_c;
    logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;
    logic [XLEN-1:0] step_hi_c, step_lo_c, final_c;
    logic [PW-1:0]   prod_c, prod_s_c;

    alu_op_decode u_dec (
        .alu_class (bus.ALUOp),
        .op        (bus.op),
        .funct3    (bus.Funct3),
        .funct7    (bus.Funct7),
        .alu_op_c  (dec_op_c)
    );

    // Single-cycle ops, evaluated on the request operands.
    always_comb begin
        shamt_c     = bus.SrcB[CW-1:0];
        basic_res_c = '0;
        case (dec_op_c)
            OP_ADD:  basic_res_c = bus.SrcA + bus.SrcB;
            OP_SUB:  basic_res_c = bus.SrcA - bus.SrcB;
            OP_SLL:  basic_res_c = bus.SrcA << shamt_c;
            OP_SLT:  basic_res_c = XLEN'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SLTU: basic_res_c = XLEN'(bus.SrcA < bus.SrcB);
            OP_XOR:  basic_res_c = bus.SrcA ^ bus.SrcB;
            OP_SRL:  basic_res_c = bus.SrcA >> shamt_c;
            OP_SRA:  basic_res_c = XLEN'($signed(bus.SrcA) >>> shamt_c);
            OP_OR:   basic_res_c = bus.SrcA | bus.SrcB;
            OP_AND:  basic_res_c = bus.SrcA & bus.SrcB;
            default: basic_res_c = '0;
        endcase
    end

    // Operand magnitudes; MULHSU treats only SrcA as signed.
    always_comb begin
        sign_a_c = bus.SrcA[XLEN-1] && (dec_op_c inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sign_b_c = bus.SrcB[XLEN-1] && (dec_op_c inside {OP_MULH, OP_DIV, OP_REM});
        mag_a_c  = sign_a_c ? -bus.SrcA : bus.SrcA;
        mag_b_c  = sign_b_c ? -bus.SrcB : bus.SrcB;
    end

    // One shift-add or restoring-divide step on {hi_q, lo_q}, plus final sign fix-up.
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
        div_shift_c = {hi_q, lo_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, d_q};
        if (is_mul_op(op_q)) begin
            step_hi_c = mul_sum_c[XLEN:1];
            step_lo_c = {mul_sum_c[0], lo_q[XLEN-1:1]};
        end else if (!div_diff_c[XLEN]) begin
            step_hi_c = div_diff_c[XLEN-1:0];
            step_lo_c = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            step_hi_c = div_shift_c[XLEN-1:0];
            step_lo_c = {lo_q[XLEN-2:0], 1'b0};
        end
        prod_c   = {step_hi_c, step_lo_c};
        prod_s_c = neg_q ? -prod_c : prod_c;
        case (op_q)
            OP_MUL:                        final_c = prod_s_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_c = prod_s_c[PW-1:XLEN];
            OP_DIV, OP_DIVU:  final_c = (d_q == '0) ? '1 : (neg_q ? -step_lo_c : step_lo_c);
            OP_REM, OP_REMU:  final_c = (d_q == '0) ? a_q : (negr_q ? -step_hi_c : step_hi_c);
            default:          final_c = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        d_d      = d_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d = dec_op_c;
                    a_d  = bus.SrcA;
                    if (is_m_op(dec_op_c)) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                        hi_d    = '0;
                        neg_d   = sign_a_c ^ sign_b_c;
                        negr_d  = sign_a_c;
                        lo_d    = is_mul_op(dec_op_c) ? mag_b_c : mag_a_c;
                        d_d     = is_mul_op(dec_op_c) ? mag_a_c : mag_b_c;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = basic_res_c;
                    end
                end
            end
            ST_CALC: begin
                hi_d  = step_hi_c;
                lo_d  = step_lo_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    result_d = final_c;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_CALC);
        zero_d      = ZERO_RST && (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            d_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= ZERO_RST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            d_q         <= d_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_q       <= neg_d;
            negr_q      <= negr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu_unit.sv
// Scoreboard bench for alu_mdu_unit (XLEN=32): directed vectors, latency/busy,
// backpressure and mid-divide reset.
module tb_alu_mdu_unit;
    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            zero;
        int              lat;
        int              busy_cyc;
        int              acc;
        int              id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // Monitor-owned state
    exp_t mon_e;
    logic prev_ov = 1'b0;
    int   busy_cnt = 0;
    logic ready_next = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mdu_unit_if #(.XLEN(XLEN)) bus ();

    alu_mdu_unit #(.XLEN(XLEN), .ZERO_FLAG_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int id, input logic [1:0] aluop, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input bit m);
        exp_t e;
        int   waited = 0;
        bus.in_valid = 1'b1;
        bus.ALUOp    = aluop;
        bus.op       = opc;
        bus.Funct3   = f3;
        bus.Funct7   = f7;
        bus.SrcA     = a;
        bus.SrcB     = b;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout id=%0d: in_ready got 0 expected 1", id);
        end else begin
            e.res      = exp_res;
            e.zero     = (exp_res == '0);
            e.lat      = m ? XLEN + 1 : 1;
            e.busy_cyc = m ? XLEN : 0;
            e.acc      = cyc;
            e.id       = id;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compares the presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov    = 1'b0;
            busy_cnt   = 0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) check("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
            ready_next = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = sb[0];
                    if (!prev_ov) begin
                        check($sformatf("latency id=%0d", mon_e.id), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                        check($sformatf("busy_cycles id=%0d", mon_e.id), 64'(busy_cnt), 64'(mon_e.busy_cyc));
                        busy_cnt = 0;
                    end
                    check($sformatf("result id=%0d", mon_e.id), 64'(bus.Result), 64'(mon_e.res));
                    check($sformatf("zero id=%0d", mon_e.id), 64'(bus.Zero), 64'(mon_e.zero));
                    if (!bus.out_ready)
                        check($sformatf("in_ready_held_low id=%0d", mon_e.id), 64'(bus.in_ready), 64'd0);
                    else begin
                        void'(sb.pop_front());
                        ready_next = 1'b1;
                    end
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: time got %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] F7_Z = 7'b0000000;
    localparam logic [6:0] F7_S = 7'b0100000;
    localparam logic [6:0] F7_M = 7'b0000001;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ALUOp     = 2'b00;
        bus.op        = 7'd0;
        bus.Funct3    = 3'd0;
        bus.Funct7    = 7'd0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy",      64'(bus.busy),      64'd0);
        check("reset_result",    64'(bus.Result),    64'd0);
        check("reset_zero",      64'(bus.Zero),      64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ops
        issue(1,  2'b10, R_OP, 3'b000, F7_S, 32'd5, 32'd7, 32'hFFFFFFFE, 0);
        issue(2,  2'b10, I_OP, 3'b000, F7_S, 32'd5, 32'd7, 32'd12, 0);
        issue(3,  2'b10, R_OP, 3'b101, F7_S, 32'h80000000, 32'd4, 32'hF8000000, 0);
        issue(4,  2'b10, R_OP, 3'b101, F7_Z, 32'h80000000, 32'd4, 32'h08000000, 0);
        issue(5,  2'b10, R_OP, 3'b001, F7_Z, 32'd1, 32'd35, 32'd8, 0);
        issue(6,  2'b10, R_OP, 3'b010, F7_Z, 32'hFFFFFFFF, 32'd1, 32'd1, 0);
        issue(7,  2'b10, R_OP, 3'b011, F7_Z, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        issue(8,  2'b10, R_OP, 3'b100, F7_Z, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0);
        issue(9,  2'b10, R_OP, 3'b110, F7_Z, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0);
        issue(10, 2'b10, R_OP, 3'b111, F7_Z, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
        issue(11, 2'b00, R_OP, 3'b000, F7_Z, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        issue(12, 2'b01, R_OP, 3'b000, F7_Z, 32'd3, 32'd5, 32'hFFFFFFFE, 0);
        issue(13, 2'b11, R_OP, 3'b100, F7_M, 32'd6, 32'd3, 32'd9, 0);
        issue(14, 2'b00, R_OP, 3'b100, F7_M, 32'd6, 32'd3, 32'd9, 0);

        // Multiply
        issue(20, 2'b10, R_OP, 3'b001, F7_M, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1);
        issue(21, 2'b10, R_OP, 3'b000, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1);
        issue(22, 2'b10, R_OP, 3'b011, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        issue(23, 2'b10, R_OP, 3'b010, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        issue(24, 2'b10, R_OP, 3'b000, F7_M, 32'd7, 32'd6, 32'd42, 1);

        // Divide, including divide-by-zero and signed overflow
        issue(30, 2'b10, R_OP, 3'b100, F7_M, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        issue(31, 2'b10, R_OP, 3'b110, F7_M, 32'd7, 32'd0, 32'd7, 1);
        issue(32, 2'b10, R_OP, 3'b100, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        issue(33, 2'b10, R_OP, 3'b110, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        issue(34, 2'b10, R_OP, 3'b110, F7_M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1);
        issue(35, 2'b10, R_OP, 3'b100, F7_M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1);
        issue(36, 2'b10, R_OP, 3'b101, F7_M, 32'd100, 32'd7, 32'd14, 1);
        issue(37, 2'b10, R_OP, 3'b111, F7_M, 32'd100, 32'd7, 32'd2, 1);
        issue(38, 2'b10, R_OP, 3'b111, F7_M, 32'h80000000, 32'd0, 32'h80000000, 1);
        wait_drain();

        // Backpressure with an ignored request while the result is held
        bus.out_ready = 1'b0;
        issue(40, 2'b01, R_OP, 3'b000, F7_Z, 32'd10, 32'd3, 32'd7, 0);
        repeat (2) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.ALUOp    = 2'b00;
        bus.SrcA     = 32'd1;
        bus.SrcB     = 32'd1;
        repeat (2) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("no_output_from_ignored_request", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a divide
        bus.in_valid = 1'b1;
        bus.ALUOp    = 2'b10;
        bus.op       = R_OP;
        bus.Funct3   = 3'b100;
        bus.Funct7   = F7_M;
        bus.SrcA     = 32'd1000;
        bus.SrcB     = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("busy_during_divide", 64'(bus.busy), 64'd1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset_in_ready",  64'(bus.in_ready),  64'd1);
        check("midreset_result",    64'(bus.Result),    64'd0);
        check("midreset_zero",      64'(bus.Zero),      64'd1);
        check("midreset_busy",      64'(bus.busy),      64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(50, 2'b10, R_OP, 3'b101, F7_M, 32'd100, 32'd7, 32'd14, 1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
